// File: rtl/e203_tcm_sram_ctrl.sv
// ICB slave to single-port TCM SRAM bridge: one access per command, response one cycle later,
// read data held under stall, light-sleep after idle. Optional macro E203_TCM_ADDR_CHK_EN flags out-of-range addresses.
module e203_tcm_sram_ctrl #(
    parameter int DW          = 32,
    parameter int MW          = 4,
    parameter int AW          = 32,
    parameter int RAM_AW      = 14,
    parameter int ADDR_LSB    = 2,
    parameter int LS_IDLE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_icb_cmd_valid,
    output logic              o_icb_cmd_ready,
    input  logic [AW-1:0]     i_icb_cmd_addr,
    input  logic              i_icb_cmd_read,
    input  logic [DW-1:0]     i_icb_cmd_wdata,
    input  logic [MW-1:0]     i_icb_cmd_wmask,
    output logic              o_icb_rsp_valid,
    input  logic              i_icb_rsp_ready,
    output logic [DW-1:0]     o_icb_rsp_rdata,
    output logic              o_icb_rsp_err,
    output logic              o_ram_cs,
    output logic              o_ram_we,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic [MW-1:0]     o_ram_wem,
    output logic [DW-1:0]     o_ram_din,
    input  logic [DW-1:0]     i_ram_dout,
    output logic              o_ram_sd,
    output logic              o_ram_ds,
    output logic              o_ram_ls,
    output logic              o_ctrl_busy,
    output logic [1:0]        o_rsp_state
);

    // Handshakes: a transfer happens on a channel in every cycle where valid and ready are both 1;
    // valid never waits on ready, and rsp payload is stable while rsp_valid=1 and rsp_ready=0.
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_LIVE = 2'd1, S_HELD = 2'd2} rsp_state_e;

    localparam int LS_CW = (LS_IDLE_CYC > 0) ? $clog2(LS_IDLE_CYC + 1) : 1;
    localparam logic [LS_CW-1:0] LS_MAX = LS_CW'(LS_IDLE_CYC);

    rsp_state_e        r_state;
    rsp_state_e        w_state_nxt;
    logic              r_rsp_rd;
    logic              r_err;
    logic [DW-1:0]     r_hold;
    logic [LS_CW-1:0]  r_idle_cnt;
    logic [LS_CW-1:0]  w_cnt_inc;
    logic              r_ls;
    logic              w_hs;
    logic              w_rsp_hs;
    logic              w_oor;
    logic              w_idle;
    logic [DW-1:0]     w_rdata;
    logic              w_unused;

`ifdef E203_TCM_ADDR_CHK_EN
    assign w_oor = |i_icb_cmd_addr[AW-1:RAM_AW+ADDR_LSB];
`else
    assign w_oor = 1'b0;
`endif

    // Byte offset bits never reach the SRAM; upper bits only matter for the range check.
    assign w_unused = ^{i_icb_cmd_addr[ADDR_LSB-1:0], i_icb_cmd_addr[AW-1:RAM_AW+ADDR_LSB]};

    assign o_icb_rsp_valid = (r_state != S_EMPTY);
    assign o_icb_cmd_ready = ~r_ls & (~o_icb_rsp_valid | i_icb_rsp_ready);
    assign w_hs            = i_icb_cmd_valid & o_icb_cmd_ready;
    assign w_rsp_hs        = o_icb_rsp_valid & i_icb_rsp_ready;

    assign o_ram_cs   = w_hs & ~w_oor;
    assign o_ram_we   = ~i_icb_cmd_read;
    assign o_ram_addr = i_icb_cmd_addr[RAM_AW+ADDR_LSB-1:ADDR_LSB];
    assign o_ram_wem  = i_icb_cmd_read ? '0 : i_icb_cmd_wmask;
    assign o_ram_din  = i_icb_cmd_wdata;
    assign o_ram_sd   = 1'b0;
    assign o_ram_ds   = 1'b0;
    assign o_ram_ls   = r_ls;

    assign o_icb_rsp_rdata = w_rdata;
    assign o_icb_rsp_err   = r_err;
    assign o_ctrl_busy     = o_icb_rsp_valid | i_icb_cmd_valid;
    assign o_rsp_state     = r_state;

    always_comb begin
        w_state_nxt = r_state;
        if (w_hs) begin
            w_state_nxt = S_LIVE;
        end else if (w_rsp_hs) begin
            w_state_nxt = S_EMPTY;
        end else if (r_state == S_LIVE) begin
            w_state_nxt = S_HELD;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (r_state)
            S_LIVE:  w_rdata = r_rsp_rd ? i_ram_dout : '0;
            S_HELD:  w_rdata = r_hold;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_EMPTY;
            r_rsp_rd <= 1'b0;
            r_err    <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_rsp_rd <= i_icb_cmd_read & ~w_oor;
                r_err    <= w_oor;
            end else if (w_rsp_hs) begin
                r_rsp_rd <= 1'b0;
                r_err    <= 1'b0;
            end
            // SRAM dout is only valid for one cycle, so a stalled live read must be captured now.
            if ((r_state == S_LIVE) && !i_icb_rsp_ready) begin
                r_hold <= w_rdata;
            end
        end
    end

    assign w_idle    = ~w_hs & ~o_icb_rsp_valid;
    assign w_cnt_inc = r_idle_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
            r_ls       <= 1'b0;
        end else if (r_ls && i_icb_cmd_valid) begin
            // Wake cycle: cmd_ready stays low now, the command is accepted next cycle.
            r_idle_cnt <= '0;
            r_ls       <= 1'b0;
        end else if (!w_idle) begin
            r_idle_cnt <= '0;
        end else if ((LS_IDLE_CYC != 0) && (r_idle_cnt != LS_MAX)) begin
            r_idle_cnt <= w_cnt_inc;
            if (w_cnt_inc == LS_MAX) begin
                r_ls <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_e203_tcm_sram_ctrl.sv
// Directed bench for e203_tcm_sram_ctrl: response-queue model checked every cycle plus literal expectations.
module tb_e203_tcm_sram_ctrl;

  localparam int LS_IDLE_CYC = 16;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_cs;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_sd;
  logic        ram_ds;
  logic        ram_ls;
  logic        ctrl_busy;
  logic [1:0]  rsp_state;
  logic        garbage_en;

  int n_tests = 0;
  int n_fail  = 0;

  e203_tcm_sram_ctrl #(.LS_IDLE_CYC(LS_IDLE_CYC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_icb_cmd_valid (cmd_valid),
    .o_icb_cmd_ready (cmd_ready),
    .i_icb_cmd_addr  (cmd_addr),
    .i_icb_cmd_read  (cmd_read),
    .i_icb_cmd_wdata (cmd_wdata),
    .i_icb_cmd_wmask (cmd_wmask),
    .o_icb_rsp_valid (rsp_valid),
    .i_icb_rsp_ready (rsp_ready),
    .o_icb_rsp_rdata (rsp_rdata),
    .o_icb_rsp_err   (rsp_err),
    .o_ram_cs        (ram_cs),
    .o_ram_we        (ram_we),
    .o_ram_addr      (ram_addr),
    .o_ram_wem       (ram_wem),
    .o_ram_din       (ram_din),
    .i_ram_dout      (ram_dout),
    .o_ram_sd        (ram_sd),
    .o_ram_ds        (ram_ds),
    .o_ram_ls        (ram_ls),
    .o_ctrl_busy     (ctrl_busy),
    .o_rsp_state     (rsp_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- SRAM model ----------------
  logic [31:0] sram [int];

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        logic [31:0] w;
        w = sram.exists(int'(ram_addr)) ? sram[int'(ram_addr)] : 32'h0;
        for (int b = 0; b < 4; b++) if (ram_wem[b]) w[b*8 +: 8] = ram_din[b*8 +: 8];
        sram[int'(ram_addr)] = w;
      end else begin
        ram_dout <= sram.exists(int'(ram_addr)) ? sram[int'(ram_addr)] : 32'h0;
      end
    end else if (garbage_en) begin
      ram_dout <= $urandom;
    end
  end

  // ---------------- scoreboard / behavioural model ----------------
  logic [32:0] exp_q[$];
  logic [31:0] exp_mem [int];
  int          m_idle;
  bit          m_ls;

  function automatic bit addr_oor(input logic [31:0] a);
`ifdef E203_TCM_ADDR_CHK_EN
    return (a >> 16) != 0;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_idle = 0;
      m_ls   = 1'b0;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_ram_ls", ram_ls, 0);
      chk("rst_ram_cs", ram_cs, 0);
    end else begin
      bit          m_ready, m_hs, m_oor, m_pend, m_cs;
      int          word;
      logic [31:0] rd_val;
      m_pend  = exp_q.size() != 0;
      m_ready = !m_ls && (!m_pend || rsp_ready);
      m_hs    = cmd_valid && m_ready;
      m_oor   = addr_oor(cmd_addr);
      m_cs    = m_hs && !m_oor;
      word    = int'((cmd_addr >> 2) & 32'h3FFF);

      chk("m_cmd_ready", cmd_ready, m_ready);
      chk("m_rsp_valid", rsp_valid, m_pend);
      if (m_pend) begin
        chk("m_rsp_rdata", rsp_rdata, exp_q[0][31:0]);
        chk("m_rsp_err", rsp_err, exp_q[0][32]);
      end
      chk("m_ram_ls", ram_ls, m_ls);
      chk("m_ram_sd_ds", {ram_sd, ram_ds}, 0);
      chk("m_ram_cs", ram_cs, m_cs);
      chk("m_busy", ctrl_busy, m_pend || cmd_valid);
      if (m_cs) begin
        chk("m_ram_addr", ram_addr, word);
        chk("m_ram_we", ram_we, !cmd_read);
        chk("m_ram_wem", ram_wem, cmd_read ? 4'h0 : cmd_wmask);
        chk("m_ram_din", ram_din, cmd_wdata);
      end

      if (m_pend && rsp_ready) void'(exp_q.pop_front());
      if (m_hs) begin
        rd_val = exp_mem.exists(word) ? exp_mem[word] : 32'h0;
        if (m_oor) exp_q.push_back({1'b1, 32'h0});
        else if (cmd_read) exp_q.push_back({1'b0, rd_val});
        else begin
          exp_q.push_back({1'b0, 32'h0});
          for (int b = 0; b < 4; b++) if (cmd_wmask[b]) rd_val[b*8 +: 8] = cmd_wdata[b*8 +: 8];
          exp_mem[word] = rd_val;
        end
      end

      if (m_ls && cmd_valid) begin
        m_ls   = 1'b0;
        m_idle = 0;
      end else if (m_hs || m_pend) begin
        m_idle = 0;
      end else if (m_idle < LS_IDLE_CYC) begin
        m_idle++;
        if (m_idle == LS_IDLE_CYC) m_ls = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_wmask = wm;
  endtask

  task automatic drive_idle();
    cmd_valid = 1'b0;
    cmd_read  = 1'b1;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    cmd_wmask = 4'h0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] rd_exp [3];

  initial begin
    rst_n      = 1'b0;
    rsp_ready  = 1'b1;
    garbage_en = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle into light-sleep
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("ls_low_idle", ram_ls, 0);
      chk("sd_ds_low", {ram_sd, ram_ds}, 0);
    end
    @(negedge clk);
    chk("ls_high_c17", ram_ls, 1);

    // wake with a read: one-cycle penalty
    step();
    drive_cmd(1'b1, 32'h40, 32'h0, 4'h0);
    @(negedge clk);
    chk("wake_ls_still", ram_ls, 1);
    chk("wake_ready_low", cmd_ready, 0);
    step();
    @(negedge clk);
    chk("wake_ls_fell", ram_ls, 0);
    chk("wake_hs_ready", cmd_ready, 1);
    chk("wake_cs", ram_cs, 1);
    step();
    drive_idle();
    @(negedge clk);
    chk("wake_rsp_valid", rsp_valid, 1);
    chk("wake_rsp_rdata", rsp_rdata, 32'h0);

    // write then read 0x40
    step();
    drive_cmd(1'b0, 32'h40, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("wr_cs", ram_cs, 1);
    chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_addr, 14'h10);
    chk("wr_wem", ram_wem, 4'hF);
    step();
    drive_cmd(1'b1, 32'h40, 32'h0, 4'h0);
    @(negedge clk);
    chk("wr_rsp_rdata0", rsp_rdata, 32'h0);
    chk("rd_addr", ram_addr, 14'h10);
    chk("rd_we", ram_we, 0);
    step();
    drive_idle();
    @(negedge clk);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);

    // preload words, including a partial-mask overwrite
    step(); drive_cmd(1'b0, 32'h0, 32'h11111111, 4'hF);
    step(); drive_cmd(1'b0, 32'h4, 32'h22222222, 4'hF);
    step(); drive_cmd(1'b0, 32'h8, 32'h33333333, 4'hF);
    step(); drive_cmd(1'b0, 32'h8, 32'hAABBCCDD, 4'b0101);

    // back-to-back reads
    rd_exp[0] = 32'h11111111;
    rd_exp[1] = 32'h22222222;
    rd_exp[2] = 32'h33BB33DD;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) drive_cmd(1'b1, 32'(i * 4), 32'h0, 4'h0);
      else drive_idle();
      @(negedge clk);
      if (i < 3) chk("b2b_ready", cmd_ready, 1);
      if (i > 0) begin
        chk("b2b_rsp_valid", rsp_valid, 1);
        chk("b2b_rsp_rdata", rsp_rdata, rd_exp[i-1]);
      end
    end

    // stalled read with garbage on ram_dout
    step();
    drive_cmd(1'b1, 32'h4, 32'h0, 4'h0);
    rsp_ready  = 1'b0;
    garbage_en = 1'b1;
    @(negedge clk);
    chk("stall_cs", ram_cs, 1);
    step();
    drive_cmd(1'b1, 32'h8, 32'h0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, 32'h22222222);
      chk("stall_ready_low", cmd_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("unstall_rdata", rsp_rdata, 32'h22222222);
    chk("unstall_ready", cmd_ready, 1);
    step();
    drive_idle();
    @(negedge clk);
    chk("after_stall_rdata", rsp_rdata, 32'h33BB33DD);
    step();
    garbage_en = 1'b0;

    // stalled write response carries zero data
    drive_cmd(1'b0, 32'hC, 32'h44444444, 4'hF);
    rsp_ready = 1'b0;
    step();
    drive_idle();
    @(negedge clk);
    chk("wstall_rdata", rsp_rdata, 32'h0);
    step();
    @(negedge clk);
    chk("wstall_held", rsp_valid, 1);
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    step();

    // out-of-range address
    drive_cmd(1'b1, 32'h0001_0000, 32'h0, 4'h0);
    @(negedge clk);
`ifdef E203_TCM_ADDR_CHK_EN
    chk("oor_cs", ram_cs, 0);
`else
    chk("alias_cs", ram_cs, 1);
    chk("alias_addr", ram_addr, 14'h0);
`endif
    step();
    drive_idle();
    @(negedge clk);
    chk("oor_rsp_valid", rsp_valid, 1);
`ifdef E203_TCM_ADDR_CHK_EN
    chk("oor_err", rsp_err, 1);
    chk("oor_rdata", rsp_rdata, 32'h0);
`else
    chk("alias_err", rsp_err, 0);
    chk("alias_rdata", rsp_rdata, 32'h11111111);
`endif

    // reset with a response pending
    step();
    drive_cmd(1'b1, 32'h40, 32'h0, 4'h0);
    rsp_ready = 1'b0;
    step();
    drive_idle();
    @(negedge clk);
    chk("pre_rst_pending", rsp_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", rsp_valid, 0);
    chk("async_rst_cs", ram_cs, 0);
    chk("async_rst_busy", ctrl_busy, 0);
    step();
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    step();
    drive_cmd(1'b1, 32'h40, 32'h0, 4'h0);
    @(negedge clk);
    step();
    drive_idle();
    @(negedge clk);
    chk("post_rst_rdata", rsp_rdata, 32'hDEADBEEF);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
